rf_write_queue: RTL and testbench



---
 rtl/rf_write_queue_pkg.sv | 14 +
 rtl/rf_fwd_sel.sv | 51 +++++
 rtl/rf_write_queue.sv | 148 ++++++++++++++
 tb/tb_rf_write_queue.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_queue_pkg.sv
// Shared defaults and queue-entry layout for the register-file write front end.
// An entry is packed as {valid, id[M-1:0], data[W-1:0]}, valid in the MSB.
package rf_write_queue_pkg;

    localparam int M_DEF     = 5;
    localparam int W_DEF     = 32;
    localparam int DEPTH_DEF = 4;
    localparam int ZERO_REG  = 0;

    function automatic int entry_width(input int m, input int w);
        return 1 + m + w;
    endfunction

endpackage

// File: rtl/rf_fwd_sel.sv
// Forwarding select for one decode read port: the youngest live queued write wins,
// then the staged write, then the register-file array.
module rf_fwd_sel
    import rf_write_queue_pkg::*;
#(
    parameter int M     = M_DEF,
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]         q_valid,
    input  logic [DEPTH-1:0][M-1:0]  q_id,
    input  logic [DEPTH-1:0][W-1:0]  q_data,
    input  logic [AW-1:0]            head,
    input  logic [AW-1:0]            tail,
    input  logic                     s_w,
    input  logic [M-1:0]             s_id,
    input  logic [W-1:0]             s_data,
    input  logic [M-1:0]             r_id,
    input  logic [W-1:0]             rf_data,
    output logic [W-1:0]             fwd_data
);

    logic [AW-1:0] slot;
    logic          found;
    logic          done;

    // Walk from the newest slot (tail-1) back toward head; the first hit is the youngest.
    always_comb begin
        fwd_data = rf_data;
        slot     = tail;
        found    = 1'b0;
        done     = 1'b0;
        if (r_id != M'(ZERO_REG)) begin
            for (int j = 0; j < DEPTH; j++) begin
                slot = slot - 1'b1;
                if (!done && !found && q_valid[slot] && (q_id[slot] == r_id)) begin
                    found    = 1'b1;
                    fwd_data = q_data[slot];
                end
                if (slot == head) begin
                    done = 1'b1;
                end
            end
            if (!found && s_w && (s_id == r_id)) begin
                fwd_data = s_data;
            end
        end
    end

endmodule

// File: rtl/rf_write_queue.sv
// Write-side front end of the 2R/1W register file: merges the in-order writeback (A)
// with a buffered multi-cycle writeback (B) and forwards pending writes to decode.
module rf_write_queue
    import rf_write_queue_pkg::*;
#(
    parameter int M     = M_DEF,
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          cp,
    input  logic          rst_n,
    input  logic          a_we,
    input  logic [M-1:0]  a_id,
    input  logic [W-1:0]  a_data,
    input  logic          b_valid,
    input  logic [M-1:0]  b_id,
    input  logic [W-1:0]  b_data,
    output logic          b_ready,
    output logic          w,
    output logic [M-1:0]  w_id,
    output logic [W-1:0]  w_data,
    input  logic [M-1:0]  r_id1,
    input  logic [M-1:0]  r_id2,
    input  logic [W-1:0]  rf_data1,
    input  logic [W-1:0]  rf_data2,
    output logic [W-1:0]  fwd_data1,
    output logic [W-1:0]  fwd_data2,
    output logic [AW:0]   count,
    output logic          empty
);

    localparam int          EW       = entry_width(M, W);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [EW-1:0]           q_mem [DEPTH];
    logic [DEPTH-1:0]        q_valid;
    logic [DEPTH-1:0][M-1:0] q_id;
    logic [DEPTH-1:0][W-1:0] q_data;
    logic [AW-1:0]           head;
    logic [AW-1:0]           tail;
    logic [AW:0]             cnt;

    logic                    s_w;
    logic [M-1:0]            s_id;
    logic [W-1:0]            s_data;

    logic                    a_hit;
    logic                    b_acc;
    logic                    push;
    logic                    pop;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_valid[i] = q_mem[i][EW-1];
            q_id[i]    = q_mem[i][W +: M];
            q_data[i]  = q_mem[i][W-1:0];
        end
    end

    // b_ready depends only on registered occupancy, so a full queue refuses B even on a pop cycle.
    assign b_ready = (cnt < FULL_CNT);
    assign a_hit   = a_we && (a_id != M'(ZERO_REG));
    assign b_acc   = b_valid && b_ready;
    assign push    = b_acc && (b_id != M'(ZERO_REG)) && !(a_hit && (b_id == a_id));
    assign pop     = !a_hit && (cnt != '0);

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
            s_w    <= 1'b0;
            s_id   <= '0;
            s_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_mem[i] <= '0;
            end
        end else begin
            // A is younger than anything queued, so older writes to its id are squashed.
            for (int i = 0; i < DEPTH; i++) begin
                if (a_hit && (q_id[i] == a_id)) begin
                    q_mem[i][EW-1] <= 1'b0;
                end
            end
            if (pop) begin
                q_mem[head][EW-1] <= 1'b0;
                head              <= head + 1'b1;
            end
            if (push) begin
                q_mem[tail] <= {1'b1, b_id, b_data};
                tail        <= tail + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (!push && pop) begin
                cnt <= cnt - 1'b1;
            end

            if (a_hit) begin
                s_w    <= 1'b1;
                s_id   <= a_id;
                s_data <= a_data;
            end else if (pop) begin
                s_w    <= q_valid[head];
                s_id   <= q_id[head];
                s_data <= q_data[head];
            end else begin
                s_w    <= 1'b0;
            end
        end
    end

    assign w      = s_w;
    assign w_id   = s_id;
    assign w_data = s_data;
    assign count  = cnt;
    assign empty  = (cnt == '0);

    rf_fwd_sel #(.M(M), .W(W), .DEPTH(DEPTH), .AW(AW)) u_fwd1 (
        .q_valid  (q_valid),
        .q_id     (q_id),
        .q_data   (q_data),
        .head     (head),
        .tail     (tail),
        .s_w      (s_w),
        .s_id     (s_id),
        .s_data   (s_data),
        .r_id     (r_id1),
        .rf_data  (rf_data1),
        .fwd_data (fwd_data1)
    );

    rf_fwd_sel #(.M(M), .W(W), .DEPTH(DEPTH), .AW(AW)) u_fwd2 (
        .q_valid  (q_valid),
        .q_id     (q_id),
        .q_data   (q_data),
        .head     (head),
        .tail     (tail),
        .s_w      (s_w),
        .s_id     (s_id),
        .s_data   (s_data),
        .r_id     (r_id2),
        .rf_data  (rf_data2),
        .fwd_data (fwd_data2)
    );

endmodule

// File: tb/tb_rf_write_queue.sv
// Bench for rf_write_queue: a queue-level reference model checked every cycle,
// a bench-side register file, and directed scenarios with literal expectations.
module tb_rf_write_queue;

    localparam int M     = 5;
    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          cp;
    logic          rst_n;
    logic          a_we;
    logic [M-1:0]  a_id;
    logic [W-1:0]  a_data;
    logic          b_valid;
    logic [M-1:0]  b_id;
    logic [W-1:0]  b_data;
    logic          b_ready;
    logic          w;
    logic [M-1:0]  w_id;
    logic [W-1:0]  w_data;
    logic [M-1:0]  r_id1;
    logic [M-1:0]  r_id2;
    logic [W-1:0]  rf_data1;
    logic [W-1:0]  rf_data2;
    logic [W-1:0]  fwd_data1;
    logic [W-1:0]  fwd_data2;
    logic [AW:0]   count;
    logic          empty;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    rf_write_queue #(.M(M), .W(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .cp        (cp),
        .rst_n     (rst_n),
        .a_we      (a_we),
        .a_id      (a_id),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_id      (b_id),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .w         (w),
        .w_id      (w_id),
        .w_data    (w_data),
        .r_id1     (r_id1),
        .r_id2     (r_id2),
        .rf_data1  (rf_data1),
        .rf_data2  (rf_data2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
        .count     (count),
        .empty     (empty)
    );

    initial begin
        cp = 1'b0;
        forever #5 cp = ~cp;
    end

    // Register-file array fed by the DUT write port.
    logic [W-1:0] rf [32] = '{default: '0};
    always @(posedge cp) begin
        if (w) rf[w_id] <= w_data;
    end
    assign rf_data1 = rf[r_id1];
    assign rf_data2 = rf[r_id2];

    // Reference model: pending B writes as an ordered list plus the staged write.
    typedef struct {
        bit            v;
        logic [M-1:0]  id;
        logic [W-1:0]  d;
    } ent_t;

    ent_t          mq[$];
    bit            ms_w;
    logic [M-1:0]  ms_id;
    logic [W-1:0]  ms_data;

    always @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            ms_w    = 1'b0;
            ms_id   = '0;
            ms_data = '0;
        end else begin
            automatic bit a_live = a_we && (a_id != 0);
            automatic bit room   = (mq.size() < DEPTH);
            ent_t e;
            if (a_live) begin
                foreach (mq[i]) if (mq[i].id == a_id) mq[i].v = 1'b0;
                ms_w    = 1'b1;
                ms_id   = a_id;
                ms_data = a_data;
            end else if (mq.size() > 0) begin
                e       = mq.pop_front();
                ms_w    = e.v;
                ms_id   = e.id;
                ms_data = e.d;
            end else begin
                ms_w = 1'b0;
            end
            if (b_valid && room && (b_id != 0) && !(a_live && (b_id == a_id))) begin
                e.v  = 1'b1;
                e.id = b_id;
                e.d  = b_data;
                mq.push_back(e);
            end
        end
    end

    function automatic logic [W-1:0] model_fwd(input logic [M-1:0] rid, input logic [W-1:0] rfd);
        if (rid == 0) return rfd;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].v && (mq[i].id == rid)) return mq[i].d;
        end
        if (ms_w && (ms_id == rid)) return ms_data;
        return rfd;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge cp) begin
        if (rst_n && chk_en) begin
            chk("m_w",       64'(w),         64'(ms_w));
            chk("m_w_id",    64'(w_id),      64'(ms_id));
            chk("m_w_data",  64'(w_data),    64'(ms_data));
            chk("m_count",   64'(count),     64'(mq.size()));
            chk("m_empty",   64'(empty),     64'(mq.size() == 0));
            chk("m_b_ready", 64'(b_ready),   64'(mq.size() < DEPTH));
            chk("m_fwd1",    64'(fwd_data1), 64'(model_fwd(r_id1, rf_data1)));
            chk("m_fwd2",    64'(fwd_data2), 64'(model_fwd(r_id2, rf_data2)));
        end
    end

    task automatic cyc(input bit aw, input logic [M-1:0] ai, input logic [W-1:0] ad,
                       input bit bv, input logic [M-1:0] bi, input logic [W-1:0] bd);
        a_we    = aw;
        a_id    = ai;
        a_data  = ad;
        b_valid = bv;
        b_id    = bi;
        b_data  = bd;
        @(negedge cp);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        a_we = 0; a_id = 0; a_data = 0;
        b_valid = 0; b_id = 0; b_data = 0;
        r_id1 = 0; r_id2 = 0;
        repeat (2) @(negedge cp);
        #1;
        chk("rst_w",       64'(w),       64'd0);
        chk("rst_w_id",    64'(w_id),    64'd0);
        chk("rst_w_data",  64'(w_data),  64'd0);
        chk("rst_count",   64'(count),   64'd0);
        chk("rst_empty",   64'(empty),   64'd1);
        chk("rst_b_ready", 64'(b_ready), 64'd1);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle();

        // A write appears one cycle after acceptance, lands in the array on the next edge.
        cyc(1, 3, 32'h11, 0, 0, 0);
        chk("a_w",      64'(w),      64'd1);
        chk("a_w_id",   64'(w_id),   64'd3);
        chk("a_w_data", 64'(w_data), 64'h11);
        chk("a_count",  64'(count),  64'd0);
        idle();
        chk("a_rf3",    64'(rf[3]),  64'h11);
        chk("a_idle_w", 64'(w),      64'd0);

        // Asynchronous reset while a write is staged.
        cyc(1, 5, 32'h22, 0, 0, 0);
        chk("pre_rst_w", 64'(w), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_w",     64'(w),     64'd0);
        chk("arst_count", 64'(count), 64'd0);
        @(negedge cp);
        #1;
        rst_n = 1'b1;
        idle();
        chk("arst_rf5", 64'(rf[5]), 64'd0);

        // Fill the queue while A occupies the port, then drain in order.
        cyc(1, 20, 32'h100, 1, 4, 32'hA0);
        cyc(1, 21, 32'h101, 1, 5, 32'hA1);
        cyc(1, 22, 32'h102, 1, 6, 32'hA2);
        cyc(1, 23, 32'h103, 1, 7, 32'hA3);
        chk("full_count",   64'(count),   64'd4);
        chk("full_b_ready", 64'(b_ready), 64'd0);
        cyc(0, 0, 0, 1, 8, 32'hEE);
        chk("pop1_w_id",    64'(w_id),    64'd4);
        chk("pop1_w_data",  64'(w_data),  64'hA0);
        chk("pop1_count",   64'(count),   64'd3);
        chk("pop1_b_ready", 64'(b_ready), 64'd1);
        idle();
        chk("pop2_w_id",    64'(w_id),    64'd5);
        idle();
        chk("pop3_w_id",    64'(w_id),    64'd6);
        idle();
        chk("pop4_w_data",  64'(w_data),  64'hA3);
        chk("pop4_empty",   64'(empty),   64'd1);
        idle();
        chk("drain_rf7",    64'(rf[7]),   64'hA3);
        chk("drain_rf8",    64'(rf[8]),   64'd0);

        // Squash: queued B id 9 is overridden by a younger A write.
        r_id1 = 9;
        cyc(0, 0, 0, 1, 9, 32'hB0);
        chk("sq_count1", 64'(count),     64'd1);
        chk("sq_fwdq",   64'(fwd_data1), 64'hB0);
        cyc(1, 9, 32'hC0, 0, 0, 0);
        chk("sq_fwds",   64'(fwd_data1), 64'hC0);
        chk("sq_count2", 64'(count),     64'd1);
        idle();
        chk("sq_pop_w",  64'(w),         64'd0);
        chk("sq_count3", 64'(count),     64'd0);
        chk("sq_fwdrf",  64'(fwd_data1), 64'hC0);
        idle();
        chk("sq_rf9",    64'(rf[9]),     64'hC0);

        // Same-cycle A and B to the same id: only A survives.
        cyc(1, 8, 32'h1, 1, 8, 32'h2);
        chk("same_w_data", 64'(w_data), 64'h1);
        chk("same_count",  64'(count),  64'd0);
        idle();
        idle();
        chk("same_rf8",    64'(rf[8]),  64'h1);

        // Two queued writes to id 12: the younger one is forwarded.
        r_id2 = 12;
        cyc(1, 24, 32'h300, 1, 12, 32'h5);
        cyc(1, 25, 32'h301, 1, 12, 32'h6);
        chk("fp_fwd2q",  64'(fwd_data2), 64'h6);
        chk("fp_count",  64'(count),     64'd2);
        idle();
        chk("fp_pop5",   64'(w_data),    64'h5);
        chk("fp_fwd2a",  64'(fwd_data2), 64'h6);
        idle();
        chk("fp_pop6",   64'(w_data),    64'h6);
        idle();
        chk("fp_fwd2rf", 64'(fwd_data2), 64'(rf_data2));
        chk("fp_rf12",   64'(rf[12]),    64'h6);

        // Id 0 is never written from either source.
        r_id1 = 0;
        cyc(1, 0, 32'h77, 1, 0, 32'h88);
        chk("z_w",     64'(w),         64'd0);
        chk("z_count", 64'(count),     64'd0);
        chk("z_fwd1",  64'(fwd_data1), 64'(rf_data1));
        idle();
        chk("z_w2",    64'(w),         64'd0);
        chk("z_rf0",   64'(rf[0]),     64'd0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
